// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and sequencer for the shared memory bus.
// M0 = cpu core, M1 = DMA/video fetch. One transfer at a time, IDLE -> ACCESS -> DONE -> IDLE.
// Optional access timeout is compiled in with `define BUS_ARB_TIMEOUT_EN; without it the
// ACCESS state waits for memory indefinitely and o_m0_err/o_m1_err are tied low.
module bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_data,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_ready,
  output logic              o_m0_err,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_data,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_ready,
  output logic              o_m1_err,
  output logic              o_mem_clk,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_ready,
  output logic [1:0]        o_grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic              ptr_q,      ptr_d;       // 0: M0 preferred on contention, 1: M1
  logic [1:0]        grant_q,    grant_d;
  logic              mem_clk_q,  mem_clk_d;
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] m0_data_q,  m0_data_d;
  logic [DATA_W-1:0] m1_data_q,  m1_data_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic              pick_m1;
  logic              owner_req;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             m0_err_q, m0_err_d;
  logic             m1_err_q, m1_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state and datapath decisions for the arbiter/sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mem_clk_d  = mem_clk_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    m0_data_d  = m0_data_q;
    m1_data_d  = m1_data_q;
    m0_ready_d = m0_ready_q;
    m1_ready_d = m1_ready_q;
    pick_m1    = i_m1_req && (!i_m0_req || ptr_q);
    owner_req  = grant_q[1] ? i_m1_req : i_m0_req;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 1'b1;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!i_mem_ready && (i_m0_req || i_m1_req)) begin
          if (pick_m1) begin
            grant_d    = 2'b10;
            mem_we_d   = i_m1_we;
            mem_addr_d = i_m1_addr;
            mem_data_d = i_m1_data;
          end else begin
            grant_d    = 2'b01;
            mem_we_d   = i_m0_we;
            mem_addr_d = i_m0_addr;
            mem_data_d = i_m0_data;
          end
          // Pointer always moves to the master that did not win.
          ptr_d     = ~pick_m1;
          mem_clk_d = 1'b1;
          state_d   = S_ACCESS;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      S_ACCESS: begin
        if (i_mem_ready) begin
          mem_clk_d = 1'b0;
          if (grant_q[1]) begin
            if (!mem_we_q) m1_data_d = i_mem_data;
            m1_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) m0_data_d = i_mem_data;
            m0_ready_d = 1'b1;
          end
          state_d = S_DONE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        // Abort at the edge that closes the TIMEOUT_CYCLES-th ACCESS cycle.
        else if (cnt_inc == TO_LIMIT) begin
          mem_clk_d = 1'b0;
          if (grant_q[1]) begin
            m1_data_d  = '0;
            m1_ready_d = 1'b1;
            m1_err_d   = 1'b1;
          end else begin
            m0_data_d  = '0;
            m0_ready_d = 1'b1;
            m0_err_d   = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      S_DONE: begin
        if (!owner_req) begin
          m0_ready_d = 1'b0;
          m1_ready_d = 1'b0;
          grant_d    = 2'b00;
          state_d    = S_IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
          m0_err_d   = 1'b0;
          m1_err_d   = 1'b0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; synchronous reset aborts any transfer without handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      grant_q    <= 2'b00;
      mem_clk_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      m0_data_q  <= '0;
      m1_data_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mem_clk_q  <= mem_clk_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      m0_data_q  <= m0_data_d;
      m1_data_q  <= m1_data_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
`endif
    end
  end

  assign o_grant    = grant_q;
  assign o_mem_clk  = mem_clk_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_m0_data  = m0_data_q;
  assign o_m1_data  = m1_data_q;
  assign o_m0_ready = m0_ready_q;
  assign o_m1_ready = m1_ready_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign o_m0_err   = m0_err_q;
  assign o_m1_err   = m1_err_q;
`else
  assign o_m0_err   = 1'b0;
  assign o_m1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: reset, read/write transfers, round-robin,
// mid-transfer reset, early req drop, ready-blocked grant, and (if compiled in) timeout.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        mem_clk, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_data(m0_rdata), .o_m0_ready(m0_ready), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_data(m1_rdata), .o_m1_ready(m1_ready), .o_m1_err(m1_err),
    .o_mem_clk(mem_clk), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
    .i_mem_data(mem_rdata), .i_mem_ready(mem_ready),
    .o_grant(grant)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_g;
  logic [31:0] exp_a;

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_memclk", 32'(mem_clk), 32'h0);
    check("rst_m0rdy", 32'(m0_ready), 32'h0);
    check("rst_m1rdy", 32'(m1_ready), 32'h0);
    check("rst_m0data", m0_rdata, 32'h0);
    check("rst_memaddr", mem_addr, 32'h0);
    check("rst_err", 32'({m1_err, m0_err}), 32'h0);
    rst = 1'b0;

    // M0 read 0x1234, memory answers 3 cycles later with 0xCAFE
    m0_req = 1; m0_we = 0; m0_addr = 32'h1234;
    tick();
    check("rd_memclk", 32'(mem_clk), 32'h1);
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_addr", mem_addr, 32'h1234);
    check("rd_we", 32'(mem_we), 32'h0);
    tick(); tick();
    check("rd_wait_clk", 32'(mem_clk), 32'h1);
    check("rd_wait_rdy", 32'(m0_ready), 32'h0);
    mem_ready = 1; mem_rdata = 32'hCAFE;
    tick();
    check("rd_done_clk", 32'(mem_clk), 32'h0);
    check("rd_ready", 32'(m0_ready), 32'h1);
    check("rd_data", m0_rdata, 32'hCAFE);
    mem_ready = 0;
    tick();
    check("rd_hold_rdy", 32'(m0_ready), 32'h1);
    check("rd_hold_grant", 32'(grant), 32'h1);
    m0_req = 0;
    tick();
    check("rd_rel_rdy", 32'(m0_ready), 32'h0);
    check("rd_rel_grant", 32'(grant), 32'h0);

    // M1 write 0x55 to 0x80; M1 read data must stay untouched
    m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h55;
    tick();
    check("wr_grant", 32'(grant), 32'h2);
    check("wr_we", 32'(mem_we), 32'h1);
    check("wr_addr", mem_addr, 32'h80);
    check("wr_data", mem_wdata, 32'h55);
    check("wr_memclk", 32'(mem_clk), 32'h1);
    mem_ready = 1; mem_rdata = 32'hDEAD;
    tick();
    check("wr_ready", 32'(m1_ready), 32'h1);
    check("wr_m1data", m1_rdata, 32'h0);
    mem_ready = 0; m1_req = 0;
    tick();
    check("wr_rel_rdy", 32'(m1_ready), 32'h0);
    check("wr_idle_addr", mem_addr, 32'h80);
    check("wr_idle_clk", 32'(mem_clk), 32'h0);

    // Both masters requesting: alternate M0, M1, M0, M1
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 32'h100 : 32'h200;
      tick();
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_addr", mem_addr, exp_a);
      check("rr_memclk", 32'(mem_clk), 32'h1);
      mem_ready = 1; mem_rdata = 32'h10 + 32'(k);
      tick();
      check("rr_clk_low", 32'(mem_clk), 32'h0);
      check("rr_ready", 32'({m1_ready, m0_ready}), 32'(exp_g));
      mem_ready = 0;
      if (exp_g[0]) m0_req = 0; else m1_req = 0;
      tick();
      check("rr_idle_grant", 32'(grant), 32'h0);
      m0_req = 1; m1_req = 1;
    end
    check("rr_m0data", m0_rdata, 32'h12);
    check("rr_m1data", m1_rdata, 32'h13);
    m1_req = 0;

    // Reset pulsed mid-ACCESS; held request is re-granted afterwards
    tick();
    check("rs_grant", 32'(grant), 32'h1);
    rst = 1;
    tick();
    check("rs_memclk", 32'(mem_clk), 32'h0);
    check("rs_grant0", 32'(grant), 32'h0);
    check("rs_ready", 32'({m1_ready, m0_ready}), 32'h0);
    rst = 0;
    tick();
    check("rs_regrant", 32'(grant), 32'h1);
    check("rs_reclk", 32'(mem_clk), 32'h1);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    check("rs_done", 32'(m0_ready), 32'h1);
    mem_ready = 0; m0_req = 0;
    tick();

    // M0 drops req during ACCESS: ready high for exactly one cycle
    m0_req = 1; m0_addr = 32'h300;
    tick();
    check("dr_grant", 32'(grant), 32'h1);
    m0_req = 0;
    tick();
    check("dr_access_clk", 32'(mem_clk), 32'h1);
    mem_ready = 1; mem_rdata = 32'hBEEF;
    tick();
    check("dr_ready", 32'(m0_ready), 32'h1);
    check("dr_data", m0_rdata, 32'hBEEF);
    mem_ready = 0;
    tick();
    check("dr_ready_off", 32'(m0_ready), 32'h0);
    check("dr_grant_off", 32'(grant), 32'h0);
    tick();
    check("dr_stay_idle", 32'(grant), 32'h0);

    // Memory ready already high in IDLE blocks the grant
    mem_ready = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h400;
    tick();
    check("blk_grant", 32'(grant), 32'h0);
    check("blk_clk", 32'(mem_clk), 32'h0);
    mem_ready = 0;
    tick();
    check("blk_regrant", 32'(grant), 32'h2);
    mem_ready = 1; mem_rdata = 32'h99;
    tick();
    check("blk_m1data", m1_rdata, 32'h99);
    mem_ready = 0; m1_req = 0;
    tick();

`ifdef BUS_ARB_TIMEOUT_EN
    // Memory never answers: abort after 4 ACCESS cycles
    m0_req = 1; m0_addr = 32'h500;
    tick();
    check("to_grant", 32'(grant), 32'h1);
    tick(); tick(); tick();
    check("to_wait_clk", 32'(mem_clk), 32'h1);
    check("to_wait_err", 32'(m0_err), 32'h0);
    tick();
    check("to_err", 32'(m0_err), 32'h1);
    check("to_ready", 32'(m0_ready), 32'h1);
    check("to_data", m0_rdata, 32'h0);
    check("to_clk", 32'(mem_clk), 32'h0);
    m0_req = 0;
    tick();
    check("to_err_clr", 32'(m0_err), 32'h0);
    check("to_rdy_clr", 32'(m0_ready), 32'h0);
`else
    check("noto_err", 32'({m1_err, m0_err}), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
